// File: rtl/kbd_event_queue_pkg.sv
// Shared types and constants for the PS/2 keyboard event queue:
// prefix codes, decoder states, the event record and the letter map.
package kbd_pkg;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_t;

  // 'release' is a reserved word, so the flag is called rel
  typedef struct packed {
    logic       rel;
    logic [3:0] letter;
  } kbd_event_t;

  // Returns {valid, code}; valid is 0 for every unsupported scan code
  function automatic logic [4:0] letter_map(input logic [7:0] code);
    logic [4:0] r;
    r = 5'b0;
    case (code)
      8'h1C: r = {1'b1, 4'd0};
      8'h32: r = {1'b1, 4'd1};
      8'h21: r = {1'b1, 4'd2};
      8'h23: r = {1'b1, 4'd3};
      8'h24: r = {1'b1, 4'd4};
      8'h2B: r = {1'b1, 4'd5};
      8'h34: r = {1'b1, 4'd6};
      8'h33: r = {1'b1, 4'd7};
      8'h3B: r = {1'b1, 4'd8};
      8'h4B: r = {1'b1, 4'd9};
      8'h31: r = {1'b1, 4'd10};
      8'h44: r = {1'b1, 4'd11};
      8'h4D: r = {1'b1, 4'd12};
      8'h2D: r = {1'b1, 4'd13};
      8'h1B: r = {1'b1, 4'd14};
      8'h35: r = {1'b1, 4'd15};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kbd_event_queue_if.sv
// Valid/ready event stream from the keyboard queue to its consumer.
interface kbd_event_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_letter;
  logic       ev_release;

  modport master (output ev_valid, ev_letter, ev_release, input ev_ready);
  modport slave  (input ev_valid, ev_letter, ev_release, output ev_ready);
endinterface

// File: rtl/kbd_event_queue_ps2_rx.sv
// PS/2 byte receiver: synchronizes the raw lines, detects kbdclk falling
// edges, deframes 11-bit frames, checks odd parity/stop and abandons stalls.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbdclk,
  input  logic       kbddat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       parity_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   dat_s;
  logic [3:0]             bit_cnt;   // 0: waiting for a start bit
  logic [8:0]             shift;     // data bits then parity, LSB first
  logic [TW-1:0]          idle_cnt;

  // Lines idle high, so reset the synchronizers high to avoid a false edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
      fall     <= 1'b0;
      dat_s    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], kbdclk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], kbddat};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      fall     <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      dat_s    <= dat_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shift      <= 9'd0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      if (bit_cnt == 4'd0) begin
        idle_cnt <= '0;
        if (fall && !dat_s) begin
          bit_cnt <= 4'd1;
        end
      end else if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (dat_s && (^shift)) begin
            byte_valid <= 1'b1;
            byte_data  <= shift[7:0];
          end else begin
            parity_err <= 1'b1;
          end
        end else begin
          shift   <= {dat_s, shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt  <= 4'd0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/kbd_event_queue.sv
// PS/2 keyboard front end: prefix-tracking decoder, held-key filter and a
// circular event FIFO presented on a valid/ready stream.
module kbd_event_queue #(
  parameter int FIFO_DEPTH     = 8,
  parameter int MODE           = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      kbdclk,
  input  logic                      kbddat,
  kbd_event_queue_if.master         ev,
  output logic                      overflow,
  output logic                      parity_err
);
  import kbd_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       byte_valid;
  logic [7:0] byte_data;

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .kbdclk    (kbdclk),
    .kbddat    (kbddat),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .parity_err(parity_err)
  );

  dec_state_t  state;
  logic [15:0] held;
  logic [4:0]  map;
  logic        push;
  kbd_event_t  push_ev;

  assign map = letter_map(byte_data);

  // Prefix bytes never map to a letter, so map[4] alone marks a letter code
  always_comb begin
    push           = 1'b0;
    push_ev.rel    = (state == ST_BRK);
    push_ev.letter = map[3:0];
    if (byte_valid && map[4]) begin
      if (state == ST_IDLE && !held[map[3:0]]) begin
        push = (MODE != 0);
      end else if (state == ST_BRK) begin
        push = (MODE != 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      held  <= 16'd0;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_data == BRK_CODE) begin
            state <= ST_BRK;
          end else if (byte_data == EXT_CODE) begin
            state <= ST_EXT;
          end else if (map[4]) begin
            held[map[3:0]] <= 1'b1;
          end
        end
        ST_BRK: begin
          if (map[4]) begin
            held[map[3:0]] <= 1'b0;
          end
          state <= ST_IDLE;
        end
        ST_EXT:     state <= (byte_data == BRK_CODE) ? ST_EXT_BRK : ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  kbd_event_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  kbd_event_t  head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ev.ev_ready;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign ev.ev_valid   = !empty;
  assign ev.ev_letter  = head.letter;
  assign ev.ev_release = head.rel;

  always_ff @(posedge clk) begin
    if (push && (!full || pop)) begin
      mem[wr_ptr[AW-1:0]] <= push_ev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        if (!full || pop) begin
          wr_ptr <= wr_ptr + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/kbd_event_queue.md
# kbd_event_queue

Clocked PS/2 keyboard front end. It samples the raw `kbdclk`/`kbddat` lines in the system clock domain, deframes and parity-checks scan-code bytes, and tracks `F0` break and `E0` extended prefixes. It maps the 16 supported letter keys to 4-bit codes and buffers press/release events in a FIFO with a valid/ready handshake. It replaces the unclocked release-only letter decoder and sits between the PS/2 pins and game/control logic.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of 2, ≥2.
- `MODE`, 0: 0 = release events only, 1 = press events only, 2 = both.
- `SYNC_STAGES`, 2: synchronizer flops on `kbdclk`/`kbddat`; ≥2.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles mid-frame before the frame is abandoned.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `kbdclk`  in  1  raw PS/2 clock, asynchronous.
- `kbddat`  in  1  raw PS/2 data, asynchronous.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_letter`  out  4  head event letter code.
- `ev_release`  out  1  head event is a release (1) or a press (0).
- `overflow`  out  1  sticky; set when an event is dropped; cleared only by `rst`.
- `parity_err`  out  1  one-cycle pulse on a bad parity or bad stop bit.

## Operation
- Reset: every output is 0; the FIFO is empty; the decoder is in IDLE; the held vector is 0; the receiver waits for a start bit.
- Receiver:
  - Samples `kbddat` on each synchronized falling edge of `kbdclk`.
  - Frame is: start = 0, 8 data bits LSB first, odd parity, stop = 1.
  - A start bit of 1 is ignored and the receiver stays idle.
  - Bad parity or stop = 0: pulse `parity_err`, discard the byte, return to idle.
  - `TIMEOUT_CYCLES` with no falling edge mid-frame: discard silently and return to idle.
- Decoder FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: `F0` → BRK; `E0` → EXT; any other byte is a make code.
  - BRK: the byte is a break code → IDLE.
  - EXT: `F0` → EXT_BRK; any other byte → IDLE.
  - EXT_BRK: any byte → IDLE.
  - Extended-key codes are consumed and never produce events.
- Letter map (shared constant): 1C→0, 32→1, 21→2, 23→3, 24→4, 2B→5, 34→6, 33→7, 3B→8, 4B→9, 31→10, 44→11, 4D→12, 2D→13, 1B→14, 35→15.
  - Unmapped codes, including shift codes `12` and `59`, produce no event.
- Held filter: a 16-bit vector tracks which letters are down.
  - A make of a letter already held is a typematic repeat and is suppressed.
  - A make sets the letter's bit; a break clears it.
  - A break of a letter not held still emits an event (key held before reset).
- An event is generated only if `MODE` permits its type, and is then pushed.
- FIFO full at push with no simultaneous pop: the new event is dropped and `overflow` is set. Stored contents are unchanged.

## Timing
- Falling-edge detect lags the pin by `SYNC_STAGES`+1 cycles.
- Decoded byte strobe: 1 cycle after the stop-bit sample.
- FSM and held vector update on the strobe cycle. The pushed event is visible on `ev_*` on the next cycle if the FIFO was empty (2 cycles after the stop-bit sample).
- Handshake: pop happens when `ev_valid && ev_ready`.
  - `ev_letter`/`ev_release` are stable while `ev_valid && !ev_ready`.
  - The next entry appears the cycle after a pop.
- Simultaneous push and pop when full: both succeed; no overflow.
- Simultaneous push and pop when empty: no bypass. The event appears the next cycle.
- `parity_err` is asserted the cycle after the stop-bit sample.
- `rst` asserted mid-frame or mid-prefix: immediate clear to reset state. The partial frame is lost; the receiver resynchronizes on the next start bit.

## Structure
- Package `kbd_pkg`:
  - letter-map function (byte → {valid, 4-bit code});
  - constants `BRK_CODE`=8'hF0 and `EXT_CODE`=8'hE0;
  - decoder state enum;
  - event struct {release, letter[3:0]}.
- Sub-module `ps2_rx`: synchronizer, edge detect, 11-bit shift, parity, timeout. It outputs `byte_valid`, `byte_data[7:0]`, and `parity_err`.
- FIFO is inline: circular buffer, pointers of log2(`FIFO_DEPTH`)+1 bits, full/empty from MSB compare.

## Test plan
- MODE=0, frames `1C`, `F0 1C` → exactly one event: letter 0, release 1. `ev_valid` rises 2 cycles after the final stop bit.
- MODE=2, frames `32 32 32 F0 32` → two events: {1,press}, then {1,release}. The repeats are suppressed.
- MODE=2, frames `E0 1C E0 F0 1C 12 F0 12` → no events; FSM ends in IDLE.
- Frame `1C` with even parity → `parity_err` pulses for 1 cycle, no event, and the following valid frame decodes normally.
- FIFO_DEPTH=4, `ev_ready`=0, 5 release events → four entries held, `overflow`=1. Drain yields the first 4 letters in order.
- `rst` pulsed after 5 data bits of a frame → all outputs 0. The next complete `F0 35` sequence yields letter 15, release.
